// File: rtl/spi_sniffer_pkg.sv
// Shared types and helpers for the passive SPI frame sniffer and its edge detector.
package spi_sniffer_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ARMED     = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // Sampling happens on the rising SCLK edge whenever CPOL and CPHA agree.
  function automatic bit sample_rising(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

  function automatic int cnt_width(input int word_width);
    return $clog2(word_width) + 1;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers synchronized SCLK/SS and produces one-cycle sample-edge and SS transition pulses.
module spi_edge_detect #(
  parameter bit CPOL          = 1'b0,
  parameter bit SAMPLE_RISING = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic ss_i,
  output logic sample_edge_o,
  output logic ss_fall_o,
  output logic ss_rise_o
);

  logic sclk_q;
  logic ss_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= CPOL;
      ss_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_i;
      ss_q   <= ss_i;
    end
  end

  assign sample_edge_o = SAMPLE_RISING ? (sclk_i & ~sclk_q) : (~sclk_i & sclk_q);
  assign ss_fall_o     = ss_q & ~ss_i;
  assign ss_rise_o     = ~ss_q & ss_i;

endmodule

// File: rtl/spi_frame_sniffer.sv
// Passive SPI deserializer: assembles MOSI/MISO words per frame and flags frame start/end.
// State | meaning: WAIT_IDLE - wait for SS high after reset; ARMED - idle bus, wait for SS fall; ACTIVE - in frame, sampling.
module spi_frame_sniffer
  import spi_sniffer_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                                sys_clk,
  input  logic                                rst,
  input  logic                                sclk_in,
  input  logic                                ss_in,
  input  logic                                mosi_in,
  input  logic                                miso_in,
  output logic                                word_valid,
  output logic [WORD_WIDTH-1:0]               mosi_word,
  output logic [WORD_WIDTH-1:0]               miso_word,
  output logic [IDX_WIDTH-1:0]                word_idx,
  output logic                                frame_start,
  output logic                                frame_end,
  output logic                                frame_partial,
  output logic [$clog2(WORD_WIDTH):0]         partial_bits
);

  localparam int CW            = cnt_width(WORD_WIDTH);
  localparam bit SAMPLE_RISING = sample_rising(CPOL, CPHA);

  state_e                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_WIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic [WORD_WIDTH-1:0]   mosi_sr_q, mosi_sr_d, miso_sr_q, miso_sr_d;
  logic [WORD_WIDTH-1:0]   mosi_word_q, mosi_word_d, miso_word_q, miso_word_d;
  logic [IDX_WIDTH-1:0]    word_idx_q, word_idx_d;
  logic                    word_valid_q, word_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_end_q, frame_end_d;
  logic                    frame_partial_q, frame_partial_d;
  logic [CW-1:0]           partial_bits_q, partial_bits_d;
  logic [WORD_WIDTH-1:0]   mosi_shift, miso_shift;
  logic                    sample_edge, ss_fall, ss_rise;

  spi_edge_detect #(
    .CPOL          (CPOL),
    .SAMPLE_RISING (SAMPLE_RISING)
  ) u_edge (
    .clk_i         (sys_clk),
    .rst_i         (rst),
    .sclk_i        (sclk_in),
    .ss_i          (ss_in),
    .sample_edge_o (sample_edge),
    .ss_fall_o     (ss_fall),
    .ss_rise_o     (ss_rise)
  );

  assign mosi_shift = MSB_FIRST ? {mosi_sr_q[WORD_WIDTH-2:0], mosi_in}
                                : {mosi_in, mosi_sr_q[WORD_WIDTH-1:1]};
  assign miso_shift = MSB_FIRST ? {miso_sr_q[WORD_WIDTH-2:0], miso_in}
                                : {miso_in, miso_sr_q[WORD_WIDTH-1:1]};

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    mosi_sr_d       = mosi_sr_q;
    miso_sr_d       = miso_sr_q;
    mosi_word_d     = mosi_word_q;
    miso_word_d     = miso_word_q;
    word_idx_d      = word_idx_q;
    word_valid_d    = 1'b0;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    frame_partial_d = 1'b0;
    partial_bits_d  = '0;
    case (state_q)
      WAIT_IDLE: if (ss_in) state_d = ARMED;
      ARMED: begin
        if (ss_fall) begin
          state_d       = ACTIVE;
          bit_cnt_d     = '0;
          word_cnt_d    = '0;
          mosi_sr_d     = '0;
          miso_sr_d     = '0;
          frame_start_d = 1'b1;
        end
      end
      ACTIVE: begin
        // SS deassertion takes priority over a coincident sample edge.
        if (ss_rise) begin
          state_d         = ARMED;
          frame_end_d     = 1'b1;
          frame_partial_d = (bit_cnt_q != '0);
          partial_bits_d  = bit_cnt_q;
          bit_cnt_d       = '0;
          mosi_sr_d       = '0;
          miso_sr_d       = '0;
        end else if (sample_edge) begin
          mosi_sr_d = mosi_shift;
          miso_sr_d = miso_shift;
          if (bit_cnt_q == CW'(WORD_WIDTH - 1)) begin
            bit_cnt_d    = '0;
            word_valid_d = 1'b1;
            mosi_word_d  = mosi_shift;
            miso_word_d  = miso_shift;
            word_idx_d   = word_cnt_q;
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + IDX_WIDTH'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q         <= WAIT_IDLE;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      mosi_sr_q       <= '0;
      miso_sr_q       <= '0;
      mosi_word_q     <= '0;
      miso_word_q     <= '0;
      word_idx_q      <= '0;
      word_valid_q    <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
      partial_bits_q  <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      mosi_sr_q       <= mosi_sr_d;
      miso_sr_q       <= miso_sr_d;
      mosi_word_q     <= mosi_word_d;
      miso_word_q     <= miso_word_d;
      word_idx_q      <= word_idx_d;
      word_valid_q    <= word_valid_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      frame_partial_q <= frame_partial_d;
      partial_bits_q  <= partial_bits_d;
    end
  end

  assign word_valid    = word_valid_q;
  assign mosi_word     = mosi_word_q;
  assign miso_word     = miso_word_q;
  assign word_idx      = word_idx_q;
  assign frame_start   = frame_start_q;
  assign frame_end     = frame_end_q;
  assign frame_partial = frame_partial_q;
  assign partial_bits  = partial_bits_q;

endmodule

// File: tb/tb_spi_frame_sniffer.sv
// Scoreboard bench: two sniffer configurations driven by an SPI master model, events checked by a monitor.
module tb_spi_frame_sniffer;

  typedef struct {
    int         kind;   // 0 start, 1 word, 2 end
    logic [7:0] mo;
    logic [7:0] mi;
    logic [7:0] ix;
    logic       part;
    logic [3:0] pb;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sclk_s[2], ss_s[2], mosi_s[2], miso_s[2];
  logic       wv[2], fs[2], fe[2], fp[2];
  logic [7:0] mw[2], sw[2];
  logic [3:0] pb[2];
  logic [7:0] idx0;
  logic [1:0] idx1;

  ev_t        q0[$], q1[$];
  logic [7:0] fm[$], fi[$];
  int         tests = 0;
  int         fails = 0;

  // Instance 0: mode 0, MSB first, 8-bit index.
  spi_frame_sniffer #(.WORD_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .IDX_WIDTH(8)) u0 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_s[0]), .ss_in(ss_s[0]), .mosi_in(mosi_s[0]),
    .miso_in(miso_s[0]), .word_valid(wv[0]), .mosi_word(mw[0]), .miso_word(sw[0]),
    .word_idx(idx0), .frame_start(fs[0]), .frame_end(fe[0]), .frame_partial(fp[0]),
    .partial_bits(pb[0]));

  // Instance 1: mode 3, LSB first, 2-bit saturating index.
  spi_frame_sniffer #(.WORD_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .IDX_WIDTH(2)) u1 (
    .sys_clk(clk), .rst(rst), .sclk_in(sclk_s[1]), .ss_in(ss_s[1]), .mosi_in(mosi_s[1]),
    .miso_in(miso_s[1]), .word_valid(wv[1]), .mosi_word(mw[1]), .miso_word(sw[1]),
    .word_idx(idx1), .frame_start(fs[1]), .frame_end(fe[1]), .frame_partial(fp[1]),
    .partial_bits(pb[1]));

  task automatic push(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check_ev(input int i, input int kind);
    ev_t        e;
    logic [7:0] ix;
    bit         empty;
    ix = (i == 0) ? idx0 : {6'b0, idx1};
    empty = 1'b0;
    if (i == 0) begin
      if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
    end else begin
      if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
    end
    tests++;
    if (empty) begin
      fails++;
      $display("FAIL unexpected_event inst=%0d got kind=%0d required none", i, kind);
    end else if (e.kind != kind) begin
      fails++;
      $display("FAIL event_order inst=%0d got kind=%0d required kind=%0d", i, kind, e.kind);
    end else if (kind == 1) begin
      if (mw[i] !== e.mo || sw[i] !== e.mi || ix !== e.ix || fp[i] !== 1'b0 || pb[i] !== 4'd0) begin
        fails++;
        $display("FAIL word inst=%0d got mosi=%h miso=%h idx=%0d part=%b pb=%0d required mosi=%h miso=%h idx=%0d part=0 pb=0",
                 i, mw[i], sw[i], ix, fp[i], pb[i], e.mo, e.mi, e.ix);
      end
    end else if (kind == 2) begin
      if (fp[i] !== e.part || pb[i] !== e.pb) begin
        fails++;
        $display("FAIL frame_end inst=%0d got part=%b pb=%0d required part=%b pb=%0d",
                 i, fp[i], pb[i], e.part, e.pb);
      end
    end
  endtask

  task automatic mon(input int i);
    if (wv[i] && fe[i]) begin
      tests++;
      fails++;
      $display("FAIL coincide inst=%0d got word_valid=1 frame_end=1 required not both", i);
    end
    if (fs[i]) check_ev(i, 0);
    if (wv[i]) check_ev(i, 1);
    if (fe[i]) check_ev(i, 2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] ix;
      ix = (i == 0) ? idx0 : {6'b0, idx1};
      tests++;
      if ({wv[i], fs[i], fe[i], fp[i], pb[i], mw[i], sw[i], ix} !== '0) begin
        fails++;
        $display("FAIL reset_outputs inst=%0d got wv=%b fs=%b fe=%b fp=%b pb=%0d mosi=%h miso=%h idx=%0d required all 0",
                 i, wv[i], fs[i], fe[i], fp[i], pb[i], mw[i], sw[i], ix);
      end
    end
  endtask

  // One SPI bit; optional SS release exactly on the sampling edge.
  task automatic one_bit(input int i, input logic m, input logic s, input bit ss_on_sample);
    logic cpol, cpha;
    cpol = (i == 1);
    cpha = (i == 1);
    if (!cpha) begin
      mosi_s[i] = m; miso_s[i] = s;
      clks(3);
      sclk_s[i] = ~cpol;
      if (ss_on_sample) ss_s[i] = 1'b1;
      clks(3);
      sclk_s[i] = cpol;
    end else begin
      sclk_s[i] = ~cpol;
      mosi_s[i] = m; miso_s[i] = s;
      clks(3);
      sclk_s[i] = cpol;
      if (ss_on_sample) ss_s[i] = 1'b1;
      clks(3);
    end
  endtask

  // Reference model: every full word received is reported, the remainder is the partial count.
  task automatic send_frame(input int i, input int nbits, input bit coincide);
    int         eff, sat;
    bit         lsb;
    ev_t        e;
    logic [7:0] tm, ti;
    lsb = (i == 1);
    sat = (i == 0) ? 255 : 3;
    eff = coincide ? nbits - 1 : nbits;
    e = '{kind: 0, mo: 8'h0, mi: 8'h0, ix: 8'h0, part: 1'b0, pb: 4'h0};
    push(i, e);
    for (int k = 0; k < eff / 8; k++) begin
      e.kind = 1; e.mo = fm[k]; e.mi = fi[k]; e.ix = 8'((k > sat) ? sat : k);
      push(i, e);
    end
    e.kind = 2; e.part = (eff % 8) != 0; e.pb = 4'(eff % 8);
    push(i, e);
    ss_s[i] = 1'b0;
    clks(3);
    for (int b = 0; b < nbits; b++) begin
      int pos;
      tm = fm[b / 8]; ti = fi[b / 8];
      pos = lsb ? (b % 8) : (7 - b % 8);
      one_bit(i, tm[pos], ti[pos], coincide && (b == nbits - 1));
    end
    clks(3);
    ss_s[i] = 1'b1;
    clks(6);
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] s);
    fm.push_back(m);
    fi.push_back(s);
  endtask

  task automatic clear_frame();
    fm.delete();
    fi.delete();
  endtask

  initial begin
    ev_t e;
    rst = 1'b1;
    sclk_s[0] = 1'b0; sclk_s[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ss_s[i] = 1'b1; mosi_s[i] = 1'b0; miso_s[i] = 1'b0;
    end
    clks(3);
    check_reset();
    rst = 1'b0;
    clks(3);

    clear_frame(); load(8'hA5, 8'h3C); send_frame(0, 8, 1'b0);
    clear_frame(); load(8'h9F, 8'hFF); load(8'h00, 8'hEF); load(8'h00, 8'h40); send_frame(1, 24, 1'b0);
    clear_frame(); load(8'hFF, 8'hFF); send_frame(0, 5, 1'b0);
    clear_frame(); load(8'h12, 8'h34); send_frame(0, 8, 1'b0);
    clear_frame(); load(8'hC3, 8'h5A); send_frame(0, 8, 1'b1);
    clear_frame(); load(8'h81, 8'h7E); send_frame(1, 8, 1'b1);

    // Reset in the middle of a frame, then traffic while SS is still held low.
    e = '{kind: 0, mo: 8'h0, mi: 8'h0, ix: 8'h0, part: 1'b0, pb: 4'h0};
    push(0, e);
    ss_s[0] = 1'b0;
    clks(3);
    for (int b = 0; b < 3; b++) one_bit(0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    clks(2);
    check_reset();
    rst = 1'b0;
    for (int b = 0; b < 8; b++) one_bit(0, b[0], ~b[0], 1'b0);
    clks(3);
    ss_s[0] = 1'b1;
    clks(4);
    clear_frame(); load(8'h5A, 8'hA5); send_frame(0, 8, 1'b0);

    clear_frame();
    for (int k = 0; k < 6; k++) load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    send_frame(1, 48, 1'b0);
    clear_frame(); load(8'h01, 8'h80); send_frame(1, 8, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int i, nb, extra;
      i = r % 2;
      nb = $urandom_range(1, 4);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      clear_frame();
      for (int k = 0; k <= nb; k++) load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      send_frame(i, nb * 8 + extra, $urandom_range(0, 3) == 0);
    end

    clks(10);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL missing_events got pending inst0=%0d inst1=%0d required 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_sniffer.md
Name: spi_frame_sniffer

Overview:
Passive SPI deserializer that sits directly downstream of the input synchronizer, in parallel with the MITM control path. It consumes the already-synchronized sclk/ss/mosi/miso lines, detects SCLK edges in the sys_clk domain, and assembles MOSI and MISO words per SPI frame. It emits per-word strobes and frame start/end events for the MITM control logic (trigger matching, substitution decisions). The block never drives the bus.

Parameters:
WORD_WIDTH, 8, bits per word.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on first edge, 1 = sample on second edge.
MSB_FIRST, 1, 1 = first bit received lands in word MSB; 0 = lands in word LSB.
IDX_WIDTH, 8, width of the word index counter.

Ports:
sys_clk  in  1  system clock (48 MHz)
rst  in  1  synchronous, active-high reset
sclk_in  in  1  synchronized SCLK
ss_in  in  1  synchronized slave select, active low
mosi_in  in  1  synchronized MOSI
miso_in  in  1  synchronized MISO
word_valid  out  1  one-cycle strobe: a complete word is available
mosi_word  out  WORD_WIDTH  last complete MOSI word; held until next word_valid
miso_word  out  WORD_WIDTH  last complete MISO word; held until next word_valid
word_idx  out  IDX_WIDTH  index of the word within the frame, 0-based; valid with word_valid
frame_start  out  1  one-cycle strobe on ss assertion
frame_end  out  1  one-cycle strobe on ss deassertion
frame_partial  out  1  valid with frame_end: 1 if the frame ended mid-word
partial_bits  out  log2(WORD_WIDTH)+1  valid with frame_end: number of bits received in the dangling word

Behaviour:
- Reset (rst = 1 at a sys_clk edge): all outputs 0, shift registers and counters 0, sclk_q = CPOL, ss_q = 1, state = WAIT_IDLE.
- Edge detection: sclk_q is sclk_in registered. A rising edge is sclk_in = 1 and sclk_q = 0.
- Sample edge: rising when CPOL == CPHA, falling otherwise.
- State WAIT_IDLE: ignore everything. Move to ARMED when ss_in = 1. This prevents capturing a frame that was already in progress when reset was released.
- State ARMED: on the ss_in 1->0 transition (ss_q = 1, ss_in = 0):
  - go to ACTIVE;
  - clear bit_cnt and word counter;
  - pulse frame_start in the next cycle.
- State ACTIVE, on each sample edge:
  - shift mosi_in and miso_in into their shift registers in the same cycle;
  - increment bit_cnt.
- Word completion: when the WORD_WIDTH-th bit is sampled in cycle t:
  - in cycle t+1, mosi_word/miso_word hold the full words, word_idx = the current word count, and word_valid = 1 for exactly one cycle;
  - bit_cnt resets to 0;
  - the word counter increments and saturates at 2^IDX_WIDTH-1; it does not wrap.
- Non-sample edges are ignored. SCLK edges while in ARMED or WAIT_IDLE are ignored.
- ACTIVE, on ss_in 0->1:
  - in the next cycle, frame_end = 1;
  - frame_partial = (bit_cnt != 0) and partial_bits = bit_cnt;
  - discard the partial shift contents; do not raise word_valid;
  - return to ARMED.
- Simultaneous ss deassertion and sample edge in the same cycle: deassertion wins. The edge is not sampled and bit_cnt is not incremented.
- frame_partial and partial_bits are 0 whenever frame_end = 0.
- word_valid and frame_end never coincide. A word completing in cycle t followed by ss deassertion in cycle t+1 yields word_valid at t+1 and frame_end at t+2.
- Bit order: with MSB_FIRST = 1, shift left and insert at the LSB. With MSB_FIRST = 0, shift right and insert at the MSB.
- Throughput requirement: SCLK ≤ sys_clk/4, so each SCLK level lasts ≥ 2 sys_clk cycles. Behaviour above that rate is undefined.

Decomposition:
- Package spi_sniffer_pkg holds:
  - the state enum (WAIT_IDLE, ARMED, ACTIVE);
  - the derived constant SAMPLE_RISING = (CPOL == CPHA);
  - the bit-counter width function clog2(WORD_WIDTH)+1.
- One sub-module, spi_edge_detect: registers sclk_in and ss_in and outputs sample_edge, ss_fall and ss_rise as one-cycle pulses. This logic is reusable by the later injector stage.

Test Plan:
1. Mode 0, WORD_WIDTH 8: ss low, send MOSI 0xA5 and MISO 0x3C, ss high -> frame_start once; word_valid once with mosi_word = 0xA5, miso_word = 0x3C, word_idx = 0; then frame_end with frame_partial = 0.
2. Mode 3, 3-byte frame with MOSI 0x9F,0x00,0x00 and MISO 0xFF,0xEF,0x40 -> three word_valid pulses, word_idx 0,1,2, with matching words.
3. Frame aborted after 5 bits of 0xFF -> no word_valid; frame_end with frame_partial = 1, partial_bits = 5; next frame with 0x12 decodes correctly.
4. ss deasserted in the same sys_clk cycle as the 8th sample edge -> no word_valid; frame_end with partial_bits = 7.
5. rst asserted mid-frame with ss held low, then released, then 8 more SCLK edges -> no outputs; after ss goes high then low again, the next byte 0x5A decodes.
6. IDX_WIDTH = 2, 6-word frame -> word_idx sequence 0,1,2,3,3,3 (saturates); MSB_FIRST = 0 with MOSI 0x01 sent LSB-first -> mosi_word = 0x01.
